// File: rtl/l1c_pkg.sv
// Shared definitions for the set-associative L1 data cache: FSM states,
// access-type codes, byte-enable decode and address-split widths.
package l1c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_e;

    localparam logic [2:0] BYTE    = 3'b000;
    localparam logic [2:0] HWORD   = 3'b001;
    localparam logic [2:0] WORD    = 3'b010;
    localparam logic [2:0] BYTE_U  = 3'b100;
    localparam logic [2:0] HWORD_U = 3'b101;

    // Lane mask of a store; halfword accesses are assumed even-aligned.
    function automatic logic [3:0] byteEnable(logic [2:0] accType, logic [1:0] lane);
        logic [3:0] be;
        case (accType)
            BYTE, BYTE_U:   be = 4'b0001 << lane;
            HWORD, HWORD_U: be = 4'b0011 << {lane[1], 1'b0};
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic int offsetBits(int lineWords);
        return $clog2(lineWords) + 2;
    endfunction

    function automatic int indexBits(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagBits(int addrW, int sets, int lineWords);
        return addrW - offsetBits(lineWords) - indexBits(sets);
    endfunction

endpackage

// File: rtl/l1c_data_assoc_if.sv
// One-word request handshake used on both the core side and the memory side.
// The master issues requests; the slave returns read data and a stall.
interface l1c_data_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        atype;
    logic [DATA_W-1:0] rdata;
    logic              stall;

    modport master (output req, we, addr, wdata, atype, input rdata, stall);
    modport slave  (input req, we, addr, wdata, atype, output rdata, stall);
endinterface

// File: rtl/l1c_way_store.sv
// Storage of one cache way: tag, valid and data flops, a byte-masked
// line-word write port and a combinational read of the addressed set/word.
module l1c_way_store #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 22,
    parameter int IDX_W  = 6,
    parameter int WRD_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [IDX_W-1:0]    index_i,
    input  logic [WRD_W-1:0]    rdWord_i,
    output logic [TAG_W-1:0]    tag_o,
    output logic                valid_o,
    output logic [DATA_W-1:0]   rdData_o,
    input  logic                wrEn_i,
    input  logic [WRD_W-1:0]    wrWord_i,
    input  logic [DATA_W/8-1:0] wrBe_i,
    input  logic [DATA_W-1:0]   wrData_i,
    input  logic                tagWe_i,
    input  logic [TAG_W-1:0]    tag_i
);
    localparam int SETS    = 1 << IDX_W;
    localparam int ENTRIES = SETS << WRD_W;

    logic [TAG_W-1:0]  tagArr_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [DATA_W-1:0] dataArr_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (tagWe_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (tagWe_i) begin
            tagArr_q[index_i] <= tag_i;
        end
        if (wrEn_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wrBe_i[b]) begin
                    dataArr_q[{index_i, wrWord_i}][8*b +: 8] <= wrData_i[8*b +: 8];
                end
            end
        end
    end

    assign tag_o    = tagArr_q[index_i];
    assign valid_o  = valid_q[index_i];
    assign rdData_o = dataArr_q[{index_i, rdWord_i}];

endmodule

// File: rtl/l1c_data_assoc.sv
// N-way set-associative, write-through, no-write-allocate L1 data cache with
// per-set round-robin replacement, single-cycle flush and hit/miss counters.
module l1c_data_assoc
    import l1c_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cache_flush_i,
    l1c_data_assoc_if.slave     core,
    l1c_data_assoc_if.master    mem,
    output logic [CNT_W-1:0]    hit_cnt_o,
    output logic [CNT_W-1:0]    miss_cnt_o
);
    localparam int OFF_W = offsetBits(LINE_WORDS);
    localparam int IDX_W = indexBits(SETS);
    localparam int TAG_W = tagBits(ADDR_W, SETS, LINE_WORDS);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          type_q, type_d;
    logic [WRD_W-1:0]    cnt_q, cnt_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WAY_W-1:0]    ptr_q [SETS];
    logic [CNT_W-1:0]    hitCnt_q, missCnt_q;

    logic [TAG_W-1:0]    tagQ;
    logic [IDX_W-1:0]    idx;
    logic [WRD_W-1:0]    wordSel;
    logic [TAG_W-1:0]    wayTag  [WAYS];
    logic [DATA_W-1:0]   wayData [WAYS];
    logic [WAYS-1:0]     wayValid, hitVec, wayWe, tagWe;
    logic                anyHit, done, flushNow, ptrWe, hitInc, missInc;
    logic [WAY_W-1:0]    hitWay, victimSel, ptrNext;
    logic [WRD_W-1:0]    wrWord;
    logic [DATA_W/8-1:0] wrBe;
    logic [DATA_W-1:0]   wrData, coreOut;

    assign tagQ    = addr_q[ADDR_W-1 -: TAG_W];
    assign idx     = addr_q[OFF_W +: IDX_W];
    assign wordSel = addr_q[2 +: WRD_W];
    assign ptrNext = (WAYS == 1) ? '0 : ptr_q[idx] + WAY_W'(1);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l1c_way_store #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .WRD_W(WRD_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (flushNow),
            .index_i  (idx),
            .rdWord_i (wordSel),
            .tag_o    (wayTag[w]),
            .valid_o  (wayValid[w]),
            .rdData_o (wayData[w]),
            .wrEn_i   (wayWe[w]),
            .wrWord_i (wrWord),
            .wrBe_i   (wrBe),
            .wrData_i (wrData),
            .tagWe_i  (tagWe[w]),
            .tag_i    (tagQ)
        );
    end

    // Descending scan so the lowest-index hit / invalid way wins.
    always_comb begin
        hitVec    = '0;
        hitWay    = '0;
        victimSel = ptr_q[idx];
        for (int w = WAYS-1; w >= 0; w--) begin
            hitVec[w] = wayValid[w] && (wayTag[w] == tagQ);
            if (hitVec[w]) hitWay = WAY_W'(w);
            if (!wayValid[w]) victimSel = WAY_W'(w);
        end
        anyHit = |hitVec;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        done      = 1'b0;
        coreOut   = '0;
        flushNow  = 1'b0;
        ptrWe     = 1'b0;
        hitInc    = 1'b0;
        missInc   = 1'b0;
        wayWe     = '0;
        tagWe     = '0;
        wrWord    = wordSel;
        wrBe      = '0;
        wrData    = wdata_q;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        mem.atype = '0;
        case (state_q)
            S_IDLE: begin
                if (cache_flush_i) begin
                    flushNow = 1'b1;
                end else if (core.req) begin
                    addr_d  = core.addr;
                    we_d    = core.we;
                    wdata_d = core.wdata;
                    type_d  = core.atype;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (anyHit) hitInc = 1'b1;
                else        missInc = 1'b1;
                if (we_q) begin
                    if (anyHit) begin
                        wayWe[hitWay] = 1'b1;
                        wrBe = byteEnable(type_q, addr_q[1:0]);
                    end
                    state_d = S_WRITE;
                end else if (anyHit) begin
                    coreOut = wayData[hitWay];
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    victim_d = victimSel;
                    cnt_d    = '0;
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                mem.req   = 1'b1;
                mem.atype = WORD;
                mem.addr  = {tagQ, idx, cnt_q, 2'b00};
                if (!mem.stall) begin
                    wayWe[victim_q] = 1'b1;
                    wrWord = cnt_q;
                    wrBe   = '1;
                    wrData = mem.rdata;
                    cnt_d  = cnt_q + WRD_W'(1);
                    if (cnt_q == '1) begin
                        tagWe[victim_q] = 1'b1;
                        ptrWe   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                coreOut = wayData[victim_q];
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_WRITE: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = addr_q;
                mem.wdata = wdata_q;
                mem.atype = type_q;
                if (!mem.stall) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core.rdata = coreOut;
    assign core.stall = core.req & ~done;
    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;

    // Counters saturate at all-ones and survive a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            type_q    <= '0;
            cnt_q     <= '0;
            victim_q  <= '0;
            hitCnt_q  <= '0;
            missCnt_q <= '0;
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (hitInc && (hitCnt_q != '1)) hitCnt_q <= hitCnt_q + CNT_W'(1);
            if (missInc && (missCnt_q != '1)) missCnt_q <= missCnt_q + CNT_W'(1);
            if (flushNow) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else if (ptrWe) begin
                ptr_q[idx] <= ptrNext;
            end
        end
    end

endmodule

// File: tb/tb_l1c_data_assoc.sv
// Directed and randomized bench for l1c_data_assoc against a behavioural
// memory model and a set/way occupancy model of the cache.
module tb_l1c_data_assoc;
    import l1c_pkg::*;

    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cacheFlush = 1'b0;
    logic [31:0] hitCnt, missCnt;

    l1c_data_assoc_if #(.ADDR_W(32), .DATA_W(32)) coreBus ();
    l1c_data_assoc_if #(.ADDR_W(32), .DATA_W(32)) memBus ();

    l1c_data_assoc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cache_flush_i (cacheFlush),
        .core          (coreBus),
        .mem           (memBus),
        .hit_cnt_o     (hitCnt),
        .miss_cnt_o    (missCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model: sparse written words over an address-derived default.
    logic [31:0] memArr [logic [31:0]];
    int          readBeats = 0;
    int          writeCount = 0;
    int          stallMode = 0;
    int          fixedStall = 0;
    int          reqCycles = 0;
    logic [31:0] readAddrQ [$];

    // Cache occupancy model.
    bit          mValid [SETS][WAYS];
    int unsigned mTag   [SETS][WAYS];
    int          mPtr   [SETS];
    int          mHits = 0;
    int          mMisses = 0;

    function automatic logic [31:0] memRead(logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (memArr.exists(wa)) return memArr[wa];
        return {wa[15:0] ^ 16'h5A5A, wa[15:0]};
    endfunction

    function automatic logic [3:0] laneMask(logic [2:0] t, logic [1:0] lane);
        int width;
        logic [3:0] m;
        width = (t == 3'b010) ? 4 : ((t == 3'b001) || (t == 3'b101)) ? 2 : 1;
        for (int b = 0; b < 4; b++) m[b] = (b >= int'(lane)) && (b < int'(lane) + width);
        return m;
    endfunction

    always @(negedge clk) begin
        bit stall;
        logic [31:0] old, merged;
        logic [3:0] m;
        stall = 1'b0;
        if (memBus.req) begin
            case (stallMode)
                1: stall = ($urandom_range(0, 2) == 0);
                2: stall = (reqCycles < fixedStall);
                default: stall = 1'b0;
            endcase
            if (stall) begin
                reqCycles++;
            end else begin
                reqCycles = 0;
                if (memBus.we) begin
                    writeCount++;
                    old = memRead(memBus.addr);
                    m = laneMask(memBus.atype, memBus.addr[1:0]);
                    for (int b = 0; b < 4; b++)
                        merged[8*b +: 8] = m[b] ? memBus.wdata[8*b +: 8] : old[8*b +: 8];
                    memArr[{memBus.addr[31:2], 2'b00}] = merged;
                end else begin
                    readBeats++;
                    readAddrQ.push_back(memBus.addr);
                end
            end
        end else begin
            reqCycles = 0;
        end
        memBus.stall = stall;
        memBus.rdata = memRead(memBus.addr);
    end

    function automatic void modelClear(bit clearCounters);
        for (int s = 0; s < SETS; s++) begin
            mPtr[s] = 0;
            for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
        end
        if (clearCounters) begin
            mHits = 0;
            mMisses = 0;
        end
    endfunction

    function automatic bit modelAccess(bit wr, logic [31:0] a);
        int s, victim;
        int unsigned t;
        s = int'((a >> 4) % SETS);
        t = a >> 10;
        for (int w = 0; w < WAYS; w++) begin
            if (mValid[s][w] && mTag[s][w] == t) begin
                mHits++;
                return 1'b1;
            end
        end
        mMisses++;
        if (!wr) begin
            victim = -1;
            for (int w = WAYS-1; w >= 0; w--) if (!mValid[s][w]) victim = w;
            if (victim < 0) victim = mPtr[s];
            mValid[s][victim] = 1'b1;
            mTag[s][victim] = t;
            mPtr[s] = (mPtr[s] + 1) % WAYS;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] typ, input bit withFlush,
                                 output logic [31:0] rdata, output int cycles, output bit timedOut);
        @(negedge clk);
        coreBus.req   = 1'b1;
        coreBus.we    = wr;
        coreBus.addr  = addr;
        coreBus.wdata = data;
        coreBus.atype = typ;
        cacheFlush    = withFlush;
        cycles   = 0;
        timedOut = 1'b1;
        rdata    = '0;
        for (int i = 0; i < 300; i++) begin
            #1;
            cycles++;
            if (!coreBus.stall) begin
                rdata = coreBus.rdata;
                timedOut = 1'b0;
                break;
            end
            @(posedge clk);
            #1 cacheFlush = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        coreBus.req = 1'b0;
        cacheFlush  = 1'b0;
    endtask

    // expHit: 1/0 for a directed hit/miss, -1 when only the model decides.
    task automatic checkOutput(input string tag, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] typ, input bit withFlush,
                               input int expHit, input int expCycles, output logic [31:0] rdata);
        bit mHit, timedOut;
        logic [31:0] expData, hit0;
        int beats0, writes0, cycles;
        if (withFlush) modelClear(1'b0);
        mHit    = modelAccess(wr, addr);
        expData = memRead(addr);
        beats0  = readBeats;
        writes0 = writeCount;
        hit0    = hitCnt;
        applyStimulus(wr, addr, data, typ, withFlush, rdata, cycles, timedOut);
        check({tag, ".timeout"}, timedOut, 1'b0);
        if (expHit >= 0) check({tag, ".hitDelta"}, hitCnt - hit0, expHit);
        check({tag, ".hitCnt"}, hitCnt, mHits);
        check({tag, ".missCnt"}, missCnt, mMisses);
        check({tag, ".readBeats"}, readBeats - beats0, (!wr && !mHit) ? 4 : 0);
        check({tag, ".memWrites"}, writeCount - writes0, wr ? 1 : 0);
        if (!wr) check({tag, ".data"}, rdata, expData);
        if (expCycles > 0) check({tag, ".cycles"}, cycles, expCycles);
        else if (!wr && mHit) check({tag, ".hitCycles"}, cycles, 2 + int'(withFlush));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit hung;
        logic [31:0] a;
        logic [2:0] typ;
        int tsel;

        coreBus.req = 1'b0; coreBus.we = 1'b0; coreBus.addr = '0;
        coreBus.wdata = '0; coreBus.atype = '0;
        memArr[32'h100] = 32'h11; memArr[32'h104] = 32'h22;
        memArr[32'h108] = 32'h33; memArr[32'h10C] = 32'h44;
        modelClear(1'b1);

        repeat (3) @(negedge clk);
        check("rst.D_req", memBus.req, 1'b0);
        check("rst.D_write", memBus.we, 1'b0);
        check("rst.D_addr", memBus.addr, 32'h0);
        check("rst.D_in", memBus.wdata, 32'h0);
        check("rst.D_type", memBus.atype, 3'b000);
        check("rst.core_out", coreBus.rdata, 32'h0);
        check("rst.hit_cnt", hitCnt, 32'h0);
        check("rst.miss_cnt", missCnt, 32'h0);
        coreBus.req = 1'b1;
        #1 check("rst.wait_follows_req1", coreBus.stall, 1'b1);
        coreBus.req = 1'b0;
        #1 check("rst.wait_follows_req0", coreBus.stall, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] cold load and hit");
        readAddrQ.delete();
        checkOutput("coldLoad", 1'b0, 32'h100, '0, WORD, 1'b0, 0, 7, rd);
        check("coldLoad.value", rd, 32'h11);
        check("coldLoad.nReads", readAddrQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < readAddrQ.size()) check("coldLoad.D_addr", readAddrQ[i], 32'h100 + 32'(4*i));
        end
        checkOutput("hitLoad", 1'b0, 32'h104, '0, WORD, 1'b0, 1, 2, rd);
        check("hitLoad.value", rd, 32'h22);

        $display("[TB] stalled write-through stores");
        stallMode = 2; fixedStall = 3;
        checkOutput("storeWord", 1'b1, 32'h104, 32'hDEADBEEF, WORD, 1'b0, 1, 6, rd);
        checkOutput("storeByte", 1'b1, 32'h105, 32'h0000AA00, BYTE, 1'b0, 1, 6, rd);
        checkOutput("loadMerged", 1'b0, 32'h104, '0, WORD, 1'b0, 1, 2, rd);
        check("loadMerged.value", rd, 32'hDEADAAEF);

        $display("[TB] no-write-allocate");
        checkOutput("storeUncached", 1'b1, 32'h2000, 32'h12345678, WORD, 1'b0, 0, 6, rd);
        checkOutput("loadAfterStore", 1'b0, 32'h2000, '0, WORD, 1'b0, 0, 0, rd);
        check("loadAfterStore.value", rd, 32'h12345678);

        $display("[TB] flush with request");
        stallMode = 0;
        checkOutput("flushLoad", 1'b0, 32'h100, '0, WORD, 1'b1, 0, 8, rd);

        $display("[TB] round-robin replacement");
        checkOutput("rr.load0", 1'b0, 32'h0000, '0, WORD, 1'b0, 0, 7, rd);
        checkOutput("rr.load1", 1'b0, 32'h1000, '0, WORD, 1'b0, 0, 7, rd);
        checkOutput("rr.load2", 1'b0, 32'h2000, '0, WORD, 1'b0, 0, 7, rd);
        checkOutput("rr.hit1", 1'b0, 32'h1000, '0, WORD, 1'b0, 1, 2, rd);
        checkOutput("rr.miss0", 1'b0, 32'h0000, '0, WORD, 1'b0, 0, 7, rd);

        $display("[TB] reset during refill");
        @(negedge clk);
        coreBus.req = 1'b1; coreBus.we = 1'b0; coreBus.addr = 32'h3000; coreBus.atype = WORD;
        a = readBeats;
        hung = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (readBeats - a == 1) begin hung = 1'b0; break; end
            @(negedge clk);
        end
        check("rstRefill.firstBeat", hung, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstRefill.D_req", memBus.req, 1'b0);
        check("rstRefill.core_wait", coreBus.stall, 1'b1);
        check("rstRefill.miss_cnt", missCnt, 32'h0);
        @(negedge clk);
        coreBus.req = 1'b0;
        rst_n = 1'b1;
        modelClear(1'b1);
        checkOutput("rstRefill.reload", 1'b0, 32'h3000, '0, WORD, 1'b0, 0, 7, rd);

        $display("[TB] randomized traffic");
        stallMode = 1;
        for (int n = 0; n < 150; n++) begin
            tsel = $urandom_range(0, 4);
            case (tsel)
                0: typ = BYTE;
                1: typ = HWORD;
                2: typ = WORD;
                3: typ = BYTE_U;
                default: typ = HWORD_U;
            endcase
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            if (typ == BYTE || typ == BYTE_U) a = a | 32'($urandom_range(0, 3));
            else if (typ == HWORD || typ == HWORD_U) a = a | (32'($urandom_range(0, 1)) << 1);
            checkOutput("rand", ($urandom_range(0, 2) == 0), a, $urandom, typ,
                        ($urandom_range(0, 15) == 0), -1, 0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
